rom_loader_bridge: RTL and testbench

- Sits between data_io (ioctl download stream) and the SDRAM controller's loader port.
- Converts ioctl byte writes into SDRAM write slots aligned to mem_sync, buffering bytes in a small FIFO.
- Applies the ROM base mapping per ioctl_index and diverts index 0xFF (CMOS image) to the CMOS RAM port.
- Holds loader_active until every buffered byte has reached SDRAM.

---
 rtl/bbc_mem_pkg.sv | 20 ++
 rtl/rom_loader_bridge_fifo.sv | 49 ++++
 rtl/rom_loader_bridge.sv | 111 +++++++++++
 tb/tb_rom_loader_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbc_mem_pkg.sv
// Shared memory-map constants and loader types for the BBC core's SDRAM loader path.
package bbc_mem_pkg;

   localparam logic [24:0] BASE_OS     = 25'h080000;
   localparam logic [24:0] BASE_MASTER = 25'h068000;
   localparam logic [24:0] ADDR_LIMIT  = 25'h060000;
   localparam logic [7:0]  CMOS_INDEX  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } loader_state_t;

   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } loader_entry_t;

endpackage

// File: rtl/rom_loader_bridge_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module loader_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head    = mem[rd_ptr[AW-1:0]];
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define validity,
   // and leaving the array unreset lets it map onto plain RAM.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/rom_loader_bridge.sv
// Turns the data_io byte stream into mem_sync-aligned SDRAM writes and routes CMOS images to CMOS RAM.
module rom_loader_bridge
   import bbc_mem_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [24:0] BASE_OS     = bbc_mem_pkg::BASE_OS,
   parameter logic [24:0] BASE_MASTER = bbc_mem_pkg::BASE_MASTER,
   parameter logic [24:0] ADDR_LIMIT  = bbc_mem_pkg::ADDR_LIMIT
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        mem_sync,
   output logic        loader_active,
   output logic        loader_we,
   output logic [24:0] loader_addr,
   output logic [7:0]  loader_data,
   output logic        cmos_we,
   output logic [6:0]  cmos_addr,
   output logic [7:0]  cmos_di,
   output logic        overflow
);

   loader_state_t state;
   loader_state_t next_state;
   loader_entry_t push_entry;
   loader_entry_t head_entry;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          push;
   logic          drop;
   logic          is_cmos;
   logic          accept_wr;

   loader_fifo #(
      .WIDTH ($bits(loader_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (push_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (head_entry)
   );

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      accept_wr       = (state == LOAD) && ioctl_wr;
      is_cmos         = accept_wr && (ioctl_index == CMOS_INDEX);
      pop             = mem_sync && !fifo_empty;
      push            = accept_wr && !is_cmos && (ioctl_addr < ADDR_LIMIT) && (!fifo_full || pop);
      drop            = accept_wr && !is_cmos && !push;
      push_entry.addr = ioctl_addr + ((ioctl_index == 8'h00) ? BASE_OS : BASE_MASTER);
      push_entry.data = ioctl_dout;

      next_state = state;
      case (state)
         IDLE:    if (ioctl_download) next_state = LOAD;
         LOAD:    if (!ioctl_download) next_state = DRAIN;
         DRAIN: begin
            if (ioctl_download)               next_state = LOAD;
            else if (fifo_empty && mem_sync)  next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state         <= IDLE;
         loader_active <= 1'b0;
         loader_we     <= 1'b0;
         loader_addr   <= '0;
         loader_data   <= '0;
         cmos_we       <= 1'b0;
         cmos_addr     <= '0;
         cmos_di       <= '0;
         overflow      <= 1'b0;
      end else begin
         state         <= next_state;
         loader_active <= (next_state != IDLE);

         // The SDRAM side only ever moves on slot boundaries.
         if (mem_sync) begin
            loader_we <= pop;
            if (pop) begin
               loader_addr <= head_entry.addr;
               loader_data <= head_entry.data;
            end
         end

         cmos_we <= is_cmos;
         if (is_cmos) begin
            cmos_addr <= ioctl_addr[6:0];
            cmos_di   <= ioctl_dout;
         end

         if (state != LOAD && ioctl_download) overflow <= 1'b0;
         else if (drop)                       overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rom_loader_bridge.sv
// Directed and randomized stimulus for rom_loader_bridge, checked against a queue-based reference model.
module tb_rom_loader_bridge;

   localparam logic [24:0] M_BASE_OS     = 25'h080000;
   localparam logic [24:0] M_BASE_MASTER = 25'h068000;
   localparam logic [24:0] M_LIMIT       = 25'h060000;
   localparam int          M_DEPTH       = 4;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        mem_sync = 1'b0;
   logic        loader_active, loader_we, cmos_we, overflow;
   logic [24:0] loader_addr;
   logic [7:0]  loader_data, cmos_di;
   logic [6:0]  cmos_addr;

   always #5 clk_sys = ~clk_sys;

   rom_loader_bridge dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .mem_sync       (mem_sync),
      .loader_active  (loader_active),
      .loader_we      (loader_we),
      .loader_addr    (loader_addr),
      .loader_data    (loader_data),
      .cmos_we        (cmos_we),
      .cmos_addr      (cmos_addr),
      .cmos_di        (cmos_di),
      .overflow       (overflow)
   );

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   bit sync_en    = 1'b0;
   bit last_sync  = 1'b0;

   // Reference model: mode 0 idle, 1 downloading, 2 draining; queue holds {sdram_addr, data}.
   int          m_mode = 0;
   logic [32:0] q[$];
   logic        m_active, m_we, m_cmos_we, m_ovf;
   logic [24:0] m_addr;
   logic [7:0]  m_data, m_cdi;
   logic [6:0]  m_caddr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit          was_empty;
      logic [32:0] e;
      logic [24:0] a;
      if (!reset_n) begin
         q.delete();
         m_mode = 0; m_active = 0; m_we = 0; m_addr = '0; m_data = '0;
         m_cmos_we = 0; m_caddr = '0; m_cdi = '0; m_ovf = 0;
         return;
      end
      was_empty = (q.size() == 0);
      if (mem_sync) begin
         if (!was_empty) begin
            e = q.pop_front();
            m_we = 1; m_addr = e[32:8]; m_data = e[7:0];
         end else begin
            m_we = 0;
         end
      end
      m_cmos_we = 0;
      if (m_mode == 1 && ioctl_wr) begin
         if (ioctl_index == 8'hFF) begin
            m_cmos_we = 1; m_caddr = ioctl_addr[6:0]; m_cdi = ioctl_dout;
         end else if (ioctl_addr >= M_LIMIT || q.size() >= M_DEPTH) begin
            m_ovf = 1;
         end else begin
            a = ioctl_addr + ((ioctl_index == 8'h00) ? M_BASE_OS : M_BASE_MASTER);
            q.push_back({a, ioctl_dout});
         end
      end
      case (m_mode)
         0: if (ioctl_download) begin m_mode = 1; m_ovf = 0; m_active = 1; end
         1: if (!ioctl_download) m_mode = 2;
         default: begin
            if (ioctl_download) begin m_mode = 1; m_ovf = 0; end
            else if (was_empty && mem_sync) begin m_mode = 0; m_active = 0; end
         end
      endcase
   endtask

   task automatic tick();
      if (sync_en) mem_sync = (cyc % 4 == 3);
      @(posedge clk_sys);
      model_edge();
      last_sync = mem_sync;
      cyc++;
      #1;
      check("active",    loader_active, m_active);
      check("we",        loader_we,     m_we);
      check("addr",      loader_addr,   m_addr);
      check("data",      loader_data,   m_data);
      check("cmos_we",   cmos_we,       m_cmos_we);
      check("cmos_addr", cmos_addr,     m_caddr);
      check("cmos_di",   cmos_di,       m_cdi);
      check("overflow",  overflow,      m_ovf);
      ioctl_wr = 1'b0;
      mem_sync = 1'b0;
   endtask

   task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
      tick();
   endtask

   task automatic wait_write(input string tag, input logic [24:0] a, input logic [7:0] d);
      bit got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
         tick();
         if (last_sync && loader_we === 1'b1) got = 1;
      end
      check({tag, "_seen"}, got, 1);
      if (got) begin
         check({tag, "_addr"}, loader_addr, a);
         check({tag, "_data"}, loader_data, d);
      end
   endtask

   task automatic next_slot_idle(input string tag);
      bit got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
         tick();
         if (last_sync) got = 1;
      end
      check({tag, "_slot"}, got, 1);
      check({tag, "_we"}, loader_we, 0);
   endtask

   initial begin
      int n;
      // Reset
      for (int i = 0; i < 3; i++) tick();
      check("rst_active", loader_active, 0);
      check("rst_we", loader_we, 0);
      check("rst_addr", loader_addr, 0);
      check("rst_ovf", overflow, 0);
      reset_n = 1'b1;
      sync_en = 1'b1;

      // Single OS byte, then master mappings
      ioctl_download = 1'b1;
      tick(); tick();
      check("load_active", loader_active, 1);
      wr(8'h00, 25'h00010, 8'hA5);
      wait_write("os", 25'h080010, 8'hA5);
      next_slot_idle("os_after");
      wr(8'h01, 25'h00000, 8'h11);
      wait_write("master0", 25'h068000, 8'h11);
      wr(8'h40, 25'h1FFFF, 8'h22);
      wait_write("master1", 25'h087FFF, 8'h22);

      // CMOS diversion
      wr(8'hFF, 25'h0002A, 8'h5C);
      check("cmos_pulse", cmos_we, 1);
      check("cmos_a", cmos_addr, 7'h2A);
      check("cmos_d", cmos_di, 8'h5C);
      tick();
      check("cmos_end", cmos_we, 0);
      next_slot_idle("cmos_nofifo");

      // Burst into a full FIFO with no slots
      sync_en = 1'b0;
      for (int i = 0; i < 6; i++) wr(8'h00, 25'(i), 8'(8'h30 + i));
      check("burst_ovf", overflow, 1);
      sync_en = 1'b1;
      for (int i = 0; i < 4; i++) wait_write("burst", M_BASE_OS + 25'(i), 8'(8'h30 + i));
      next_slot_idle("burst_end");

      // Drain with three queued bytes
      sync_en = 1'b0;
      for (int i = 0; i < 3; i++) wr(8'h01, 25'(12'h100 + i), 8'(8'h50 + i));
      ioctl_download = 1'b0;
      sync_en = 1'b1;
      n = 0;
      for (int i = 0; i < 60 && loader_active === 1'b1; i++) begin
         tick();
         if (last_sync && loader_we === 1'b1) n++;
      end
      check("drain_writes", n, 3);
      check("drain_done", loader_active, 0);

      // New download clears overflow; address limit boundary
      ioctl_download = 1'b1;
      tick(); tick();
      check("reload_ovf", overflow, 0);
      wr(8'h00, M_LIMIT, 8'h77);
      check("limit_ovf", overflow, 1);
      wr(8'h00, M_LIMIT - 25'd1, 8'h78);
      wait_write("limit_last", 25'h0DFFFF, 8'h78);

      // Re-entry from DRAIN keeps queue; push while full with a simultaneous pop
      sync_en = 1'b0;
      for (int i = 0; i < 4; i++) wr(8'h00, 25'(12'h200 + i), 8'(8'h90 + i));
      ioctl_download = 1'b0; tick();
      ioctl_download = 1'b1; tick();
      check("reenter_ovf", overflow, 0);
      mem_sync = 1'b1;
      wr(8'h00, 25'h00204, 8'h94);
      check("full_pop_ovf", overflow, 0);
      check("full_pop_we", loader_we, 1);
      check("full_pop_addr", loader_addr, 25'h080200);
      sync_en = 1'b1;
      for (int i = 1; i < 5; i++) wait_write("fullpop", M_BASE_OS + 25'(12'h200 + i), 8'(8'h90 + i));

      // Reset mid-load discards queued bytes
      sync_en = 1'b0;
      wr(8'h00, 25'h00300, 8'hC1);
      wr(8'h00, 25'h00301, 8'hC2);
      reset_n = 1'b0; ioctl_download = 1'b0;
      tick();
      check("mid_rst_active", loader_active, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_addr", loader_addr, 0);
      reset_n = 1'b1; sync_en = 1'b1;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (loader_we === 1'b1) n++;
      end
      check("mid_rst_nowrite", n, 0);
      ioctl_download = 1'b1;
      tick(); tick();
      check("post_rst_ovf", overflow, 0);
      check("post_rst_active", loader_active, 1);

      // Randomized traffic
      sync_en = 1'b0;
      for (int i = 0; i < 800; i++) begin
         mem_sync = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) ioctl_download = ~ioctl_download;
         ioctl_wr = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: ioctl_index = 8'h00;
            1: ioctl_index = 8'h01;
            2: ioctl_index = 8'hFF;
            default: ioctl_index = 8'($urandom_range(0, 254));
         endcase
         if ($urandom_range(0, 7) == 0 && ioctl_index != 8'hFF)
            ioctl_addr = M_LIMIT + 25'($urandom_range(0, 255));
         else
            ioctl_addr = 25'($urandom_range(0, 32'h05FFFF));
         ioctl_dout = 8'($urandom);
         reset_n = ($urandom_range(0, 299) != 0);
         tick();
      end
      reset_n = 1'b1;
      ioctl_download = 1'b0;
      sync_en = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      check("final_idle", loader_active, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
